regfile_2r1w: RTL



---
 rtl/rv32_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 42 ++++
 rtl/regfile_2r1w.sv | 80 ++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I core types and constants.
// Register-file address and data widths live here.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: 32:1 mux, x0 forced
// to zero, and an optional same-cycle write forward.
module regfile_read_port
    import rv32_pkg::*;
#(
    parameter int W      = 32,
    parameter int N      = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic [N-1:1][W-1:0] i_regs,
    input  reg_addr_t           i_addr,
    input  logic                i_wr_live,
    input  reg_addr_t           i_wr_addr,
    input  logic [W-1:0]        i_wr_data,
    output logic [W-1:0]        o_data
);

    logic [W-1:0] w_stored;

    always_comb begin
        w_stored = '0;
        for (int i = 1; i < N; i++) begin
            if (i_addr == REG_ADDR_W'(i)) begin
                w_stored = i_regs[i];
            end
        end
    end

    generate
        if (BYPASS) begin : g_byp
            logic w_hit;
            assign w_hit  = i_wr_live && (i_wr_addr == i_addr);
            assign o_data = w_hit ? i_wr_data : w_stored;
        end else begin : g_nobyp
            // Write-side inputs are deliberately left unconnected here.
            logic w_unused_wr;
            assign w_unused_wr = ^{i_wr_live, i_wr_addr, i_wr_data};
            assign o_data      = w_stored;
        end
    endgenerate

endmodule

// File: rtl/regfile_2r1w.sv
// RV32I architectural register file: 2 read ports, 1 write port,
// plus an unbypassed debug read port. x0 has no storage.
module regfile_2r1w
    import rv32_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  reg_addr_t       rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  reg_addr_t       rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            rd_wren,
    input  reg_addr_t       rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  reg_addr_t       dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [NREGS-1:1][XLEN-1:0] r_regs;
    logic                       w_wr_live;

    // Gating with rst_n also suppresses the forward during reset.
    assign w_wr_live = rd_wren && rst_n && (rd_addr != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else if (w_wr_live) begin
            for (int i = 1; i < NREGS; i++) begin
                if (rd_addr == REG_ADDR_W'(i)) begin
                    r_regs[i] <= rd_data;
                end
            end
        end
    end

    regfile_read_port #(
        .W      (XLEN),
        .N      (NREGS),
        .BYPASS (BYPASS)
    ) u_rs1 (
        .i_regs    (r_regs),
        .i_addr    (rs1_addr),
        .i_wr_live (w_wr_live),
        .i_wr_addr (rd_addr),
        .i_wr_data (rd_data),
        .o_data    (rs1_data)
    );

    regfile_read_port #(
        .W      (XLEN),
        .N      (NREGS),
        .BYPASS (BYPASS)
    ) u_rs2 (
        .i_regs    (r_regs),
        .i_addr    (rs2_addr),
        .i_wr_live (w_wr_live),
        .i_wr_addr (rd_addr),
        .i_wr_data (rd_data),
        .o_data    (rs2_data)
    );

    regfile_read_port #(
        .W      (XLEN),
        .N      (NREGS),
        .BYPASS (1'b0)
    ) u_dbg (
        .i_regs    (r_regs),
        .i_addr    (dbg_addr),
        .i_wr_live (w_wr_live),
        .i_wr_addr (rd_addr),
        .i_wr_data (rd_data),
        .o_data    (dbg_data)
    );

endmodule
